// File: rtl/vreg_wb_sched_if.sv
// Writeback bus between the two vector producers, the scheduler and the register-file write port.
// The master side is the producers and register file; the slave side is the scheduler.
interface vreg_wb_sched_if #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 3
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_dst;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_dst;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_dst;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output req0_valid, req0_dst, req0_data, req1_valid, req1_dst, req1_data,
        input  req0_ready, req1_ready, wr_en, wr_dst, wr_data
    );

    modport slave (
        input  req0_valid, req0_dst, req0_data, req1_valid, req1_dst, req1_data,
        output req0_ready, req1_ready, wr_en, wr_dst, wr_data
    );
endinterface

// File: rtl/vreg_wb_sched.sv
// Round-robin writeback scheduler for the 8 x 256-bit vector register file, with a
// per-register pending scoreboard that decode uses for RAW/WAW stalls.
module vreg_wb_sched #(
    parameter  int DATA_W = 256,
    parameter  int ADDR_W = 3,
    localparam int NREGS  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    vreg_wb_sched_if.slave    bus,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_dst,
    input  logic [ADDR_W-1:0] chk_addr_1,
    input  logic [ADDR_W-1:0] chk_addr_2,
    input  logic [ADDR_W-1:0] chk_dst,
    output logic              hazard,
    output logic [NREGS-1:0]  pending,
    output logic              err
);
    logic              last_grant_q, last_grant_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_dst_q, wr_dst_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [NREGS-1:0]  pending_q, pending_d;
    logic              err_q, err_d;
    logic              gnt0, gnt1, xfer;
    logic [NREGS-1:0]  set_vec, clr_vec;

    // The requester that did not win last gets priority when both are valid.
    always_comb begin
        gnt0 = ~rst & bus.req0_valid & (~bus.req1_valid | last_grant_q);
        gnt1 = ~rst & bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
        xfer = gnt0 | gnt1;
    end

    always_comb begin
        last_grant_d = last_grant_q;
        wr_en_d      = xfer;
        wr_dst_d     = wr_dst_q;
        wr_data_d    = wr_data_q;
        if (xfer) begin
            last_grant_d = gnt1;
            wr_dst_d     = gnt1 ? bus.req1_dst  : bus.req0_dst;
            wr_data_d    = gnt1 ? bus.req1_data : bus.req0_data;
        end
    end

    // A write in flight this cycle retires its pending bit at the edge; a new issue wins over it.
    always_comb begin
        set_vec   = iss_valid ? (NREGS'(1) << iss_dst) : '0;
        clr_vec   = wr_en_q ? (NREGS'(1) << wr_dst_q) : '0;
        pending_d = set_vec | (pending_q & ~clr_vec);
        err_d     = err_q
                  | (iss_valid & pending_q[iss_dst] & ~clr_vec[iss_dst])
                  | (wr_en_q & ~pending_q[wr_dst_q]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            wr_en_q      <= 1'b0;
            wr_dst_q     <= '0;
            wr_data_q    <= '0;
            pending_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            wr_en_q      <= wr_en_d;
            wr_dst_q     <= wr_dst_d;
            wr_data_q    <= wr_data_d;
            pending_q    <= pending_d;
            err_q        <= err_d;
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_dst     = wr_dst_q;
    assign bus.wr_data    = wr_data_q;
    assign pending        = pending_q;
    assign err            = err_q;
    assign hazard         = pending_q[chk_addr_1] | pending_q[chk_addr_2] | pending_q[chk_dst];
endmodule

// File: tb/tb_vreg_wb_sched.sv
// Scoreboard bench for vreg_wb_sched: directed stimulus pushes expected register-file
// writes into a queue, a negedge monitor pops and compares every wr_en cycle.
module tb_vreg_wb_sched;
    localparam int DATA_W = 256;
    localparam int ADDR_W = 3;
    localparam int NREGS  = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] dst;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              iss_valid = 1'b0;
    logic [ADDR_W-1:0] iss_dst = '0;
    logic [ADDR_W-1:0] chk_addr_1 = '0;
    logic [ADDR_W-1:0] chk_addr_2 = '0;
    logic [ADDR_W-1:0] chk_dst = '0;
    logic              hazard;
    logic [NREGS-1:0]  pending;
    logic              err;

    int checks   = 0;
    int failures = 0;
    wr_t exp_q[$];

    vreg_wb_sched_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    vreg_wb_sched #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .iss_valid  (iss_valid),
        .iss_dst    (iss_dst),
        .chk_addr_1 (chk_addr_1),
        .chk_addr_2 (chk_addr_2),
        .chk_dst    (chk_dst),
        .hazard     (hazard),
        .pending    (pending),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        iss_valid = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic push(input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] v);
        wr_t e;
        e.dst  = d;
        e.data = v;
        exp_q.push_back(e);
    endtask

    // Monitor: every write the DUT presents must match the next expected write.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual_dst=%0d expected=none", bus.wr_dst);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_dst", DATA_W'(bus.wr_dst), DATA_W'(e.dst));
                chk("wr_data", bus.wr_data, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DATA_W-1:0] r0_data [3];
        logic [DATA_W-1:0] r1_data [3];
        logic [ADDR_W-1:0] r0_dst [3];
        logic [ADDR_W-1:0] r1_dst [3];
        int i0, i1;

        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_dst = '0;
        bus.req1_dst = '0;
        bus.req0_data = '0;
        bus.req1_data = '0;

        // Test 1: reset values, readies held low during reset, single ALU writeback
        rst = 1'b1;
        step();
        step();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        @(negedge clk);
        chk("rst_req0_ready", DATA_W'(bus.req0_ready), 0);
        chk("rst_req1_ready", DATA_W'(bus.req1_ready), 0);
        chk("rst_wr_en", DATA_W'(bus.wr_en), 0);
        chk("rst_wr_dst", DATA_W'(bus.wr_dst), 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_pending", DATA_W'(pending), 0);
        chk("rst_err", DATA_W'(err), 0);
        step();
        rst = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        iss_valid = 1'b1;
        iss_dst = 3'd3;
        step();
        iss_valid = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_dst = 3'd3;
        bus.req0_data = {32{8'hA5}};
        push(3'd3, {32{8'hA5}});
        @(negedge clk);
        chk("t1_pending_set", DATA_W'(pending), 'h08);
        chk("t1_req0_ready", DATA_W'(bus.req0_ready), 1);
        step();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        chk("t1_wr_en", DATA_W'(bus.wr_en), 1);
        chk("t1_pending_during_write", DATA_W'(pending), 'h08);
        step();
        @(negedge clk);
        chk("t1_pending_clear", DATA_W'(pending), 0);
        chk("t1_wr_en_low", DATA_W'(bus.wr_en), 0);
        chk("t1_err", DATA_W'(err), 0);

        // Test 2: contention straight from reset, req0 first, back-to-back writes
        step();
        do_reset();
        iss_valid = 1'b1;
        iss_dst = 3'd1;
        step();
        iss_dst = 3'd2;
        step();
        iss_valid = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_dst = 3'd1;
        bus.req0_data = {8{32'h1111_0001}};
        bus.req1_valid = 1'b1;
        bus.req1_dst = 3'd2;
        bus.req1_data = {8{32'h2222_0002}};
        push(3'd1, {8{32'h1111_0001}});
        push(3'd2, {8{32'h2222_0002}});
        @(negedge clk);
        chk("t2_first_ready0", DATA_W'(bus.req0_ready), 1);
        chk("t2_first_ready1", DATA_W'(bus.req1_ready), 0);
        step();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        chk("t2_second_ready1", DATA_W'(bus.req1_ready), 1);
        chk("t2_wr_en_cycle1", DATA_W'(bus.wr_en), 1);
        step();
        bus.req1_valid = 1'b0;
        @(negedge clk);
        chk("t2_wr_en_cycle2", DATA_W'(bus.wr_en), 1);
        step();
        step();
        @(negedge clk);
        chk("t2_pending", DATA_W'(pending), 0);
        chk("t2_err", DATA_W'(err), 0);

        // Test 3: both requesters held for 6 cycles alternate 0,1,0,1,0,1
        r0_dst = '{3'd0, 3'd1, 3'd2};
        r1_dst = '{3'd4, 3'd5, 3'd6};
        for (int k = 0; k < 3; k++) begin
            r0_data[k] = {8{32'hA000_0000 + 32'(k)}};
            r1_data[k] = {8{32'hB000_0000 + 32'(k)}};
        end
        step();
        iss_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            iss_dst = r0_dst[k];
            step();
            iss_dst = r1_dst[k];
            step();
        end
        iss_valid = 1'b0;
        i0 = 0;
        i1 = 0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.req0_dst  = r0_dst[i0 > 2 ? 2 : i0];
            bus.req0_data = r0_data[i0 > 2 ? 2 : i0];
            bus.req1_dst  = r1_dst[i1 > 2 ? 2 : i1];
            bus.req1_data = r1_data[i1 > 2 ? 2 : i1];
            if (k % 2 == 0) push(r0_dst[i0], r0_data[i0]);
            else            push(r1_dst[i1], r1_data[i1]);
            @(negedge clk);
            chk("t3_rr_ready0", DATA_W'(bus.req0_ready), DATA_W'(k % 2 == 0));
            chk("t3_rr_ready1", DATA_W'(bus.req1_ready), DATA_W'(k % 2 == 1));
            step();
            if (k % 2 == 0) i0++;
            else            i1++;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        step();
        @(negedge clk);
        chk("t3_pending", DATA_W'(pending), 0);
        chk("t3_err", DATA_W'(err), 0);

        // Test 4: hazard on source and destination, held through the write cycle
        step();
        iss_valid = 1'b1;
        iss_dst = 3'd5;
        step();
        iss_valid = 1'b0;
        chk_addr_1 = 3'd5;
        chk_addr_2 = 3'd0;
        chk_dst = 3'd0;
        @(negedge clk);
        chk("t4_hazard_src1", DATA_W'(hazard), 1);
        step();
        chk_addr_1 = 3'd0;
        chk_dst = 3'd5;
        @(negedge clk);
        chk("t4_hazard_dst", DATA_W'(hazard), 1);
        step();
        chk_dst = 3'd0;
        @(negedge clk);
        chk("t4_no_hazard", DATA_W'(hazard), 0);
        step();
        chk_addr_1 = 3'd5;
        bus.req0_valid = 1'b1;
        bus.req0_dst = 3'd5;
        bus.req0_data = {4{64'hC0DE_5555_0000_0005}};
        push(3'd5, {4{64'hC0DE_5555_0000_0005}});
        @(negedge clk);
        chk("t4_ready0", DATA_W'(bus.req0_ready), 1);
        step();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        chk("t4_hazard_in_write", DATA_W'(hazard), 1);
        step();
        @(negedge clk);
        chk("t4_hazard_after", DATA_W'(hazard), 0);
        chk_addr_1 = 3'd0;

        // Test 5: re-issue during the retiring write, then a write to a non-pending register
        step();
        iss_valid = 1'b1;
        iss_dst = 3'd4;
        step();
        iss_valid = 1'b0;
        bus.req1_valid = 1'b1;
        bus.req1_dst = 3'd4;
        bus.req1_data = {32{8'h44}};
        push(3'd4, {32{8'h44}});
        @(negedge clk);
        chk("t5_ready1", DATA_W'(bus.req1_ready), 1);
        step();
        bus.req1_valid = 1'b0;
        iss_valid = 1'b1;
        iss_dst = 3'd4;
        @(negedge clk);
        chk("t5_wr_en", DATA_W'(bus.wr_en), 1);
        step();
        iss_valid = 1'b0;
        @(negedge clk);
        chk("t5_pending4_kept", DATA_W'(pending), 'h10);
        chk("t5_err_clean", DATA_W'(err), 0);
        step();
        bus.req0_valid = 1'b1;
        bus.req0_dst = 3'd6;
        bus.req0_data = {32{8'h66}};
        push(3'd6, {32{8'h66}});
        @(negedge clk);
        chk("t5_ready0", DATA_W'(bus.req0_ready), 1);
        step();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        chk("t5_err_before_edge", DATA_W'(err), 0);
        step();
        @(negedge clk);
        chk("t5_err_set", DATA_W'(err), 1);
        step();
        step();
        @(negedge clk);
        chk("t5_err_sticky", DATA_W'(err), 1);

        // Test 6: reset one cycle after a transfer
        step();
        bus.req1_valid = 1'b1;
        bus.req1_dst = 3'd4;
        bus.req1_data = {32{8'h77}};
        push(3'd4, {32{8'h77}});
        @(negedge clk);
        chk("t6_ready1", DATA_W'(bus.req1_ready), 1);
        step();
        rst = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        @(negedge clk);
        chk("t6_rst_ready0", DATA_W'(bus.req0_ready), 0);
        chk("t6_rst_ready1", DATA_W'(bus.req1_ready), 0);
        step();
        @(negedge clk);
        chk("t6_rst_wr_en", DATA_W'(bus.wr_en), 0);
        chk("t6_rst_pending", DATA_W'(pending), 0);
        chk("t6_rst_err", DATA_W'(err), 0);
        chk("t6_rst_ready0_b", DATA_W'(bus.req0_ready), 0);
        step();
        rst = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        iss_valid = 1'b1;
        iss_dst = 3'd1;
        step();
        iss_dst = 3'd2;
        step();
        iss_valid = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_dst = 3'd1;
        bus.req0_data = {32{8'h81}};
        bus.req1_valid = 1'b1;
        bus.req1_dst = 3'd2;
        bus.req1_data = {32{8'h82}};
        push(3'd1, {32{8'h81}});
        push(3'd2, {32{8'h82}});
        @(negedge clk);
        chk("t6_post_ready0", DATA_W'(bus.req0_ready), 1);
        chk("t6_post_ready1", DATA_W'(bus.req1_ready), 0);
        step();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        chk("t6_post_second_ready1", DATA_W'(bus.req1_ready), 1);
        step();
        bus.req1_valid = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("t6_pending", DATA_W'(pending), 0);
        chk("t6_err", DATA_W'(err), 0);
        chk("queue_drained", DATA_W'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vreg_wb_sched.md
Name: vreg_wb_sched

Overview:
Writeback scheduler and scoreboard for the 8-entry x 256-bit vector register file. Two producers share the register file's single write port: requester 0 is the vector ALU result and requester 1 is the vector load return. The block arbitrates between them round-robin and drives a registered wr_en/wr_dst/wr_data. It also keeps a per-register pending bitmap so decode can stall on RAW/WAW hazards against in-flight writes.

Parameters:
DATA_W, 256, width of the vector data word
ADDR_W, 3, register address width; NREGS = 2**ADDR_W = 8

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
req0_valid  input  1  ALU writeback request
req0_dst  input  ADDR_W  ALU destination register
req0_data  input  DATA_W  ALU result
req0_ready  output  1  grant to requester 0 (combinational)
req1_valid  input  1  load writeback request
req1_dst  input  ADDR_W  load destination register
req1_data  input  DATA_W  load data
req1_ready  output  1  grant to requester 1 (combinational)
wr_en  output  1  register-file write enable (registered)
wr_dst  output  ADDR_W  register-file write address (registered)
wr_data  output  DATA_W  register-file write data (registered)
iss_valid  input  1  decode issues an instruction that writes iss_dst
iss_dst  input  ADDR_W  destination being marked pending
chk_addr_1  input  ADDR_W  decode source operand 1
chk_addr_2  input  ADDR_W  decode source operand 2
chk_dst  input  ADDR_W  decode destination, for WAW check
hazard  output  1  pending[chk_addr_1] | pending[chk_addr_2] | pending[chk_dst] (combinational)
pending  output  NREGS  scoreboard bitmap (registered)
err  output  1  sticky protocol-error flag

Behaviour:
- Reset values, applied at the clock edge while rst=1:
  - wr_en=0, wr_dst=0, wr_data=0.
  - pending=0, err=0.
  - last_grant=1, so requester 0 has priority first.
  - While rst=1, req0_ready=req1_ready=0.
- Arbitration, combinational, at most one ready per cycle:
  - Only one valid: that requester gets ready.
  - Both valid: the requester that is not last_grant gets ready.
  - Neither valid: no ready.
- Transfer = valid & ready. On a transfer edge: last_grant <= granted index.
  - last_grant holds when there is no transfer.
- Requester rule: once valid is asserted, dst and data stay stable until the transfer.
  - Round-robin guarantees a held request is granted within 2 cycles.
- Write port, latency 1: at a transfer edge, wr_en<=1, wr_dst<=granted dst, wr_data<=granted data.
  - With no transfer, wr_en<=0 and wr_dst/wr_data hold.
  - Back-to-back transfers give wr_en high on consecutive cycles.
- Scoreboard update at each edge, per register d:
  - set_d = iss_valid & iss_dst==d.
  - clr_d = wr_en & wr_dst==d, i.e. the write completes during the current wr_en cycle.
  - pending[d] <= set_d | (pending[d] & ~clr_d).
  - Simultaneous set and clear of the same d: set wins, pending stays 1.
- Hazard is purely combinational from the current pending bits.
  - A register being written in the current wr_en cycle still reports a hazard.
  - Its bit clears at that edge.
- err is set (sticky until rst) on either:
  - iss_valid with pending[iss_dst]=1, unless it is cleared that same edge;
  - a wr_en cycle where pending[wr_dst]=0.
  - The write itself is still performed; the pending update is unaffected.
- Reset mid-operation discards any granted-but-unwritten data: wr_en=0 after reset and nothing is replayed.

Test Plan:
1. Reset, then iss_valid with iss_dst=3; next cycle req0_valid with dst=3, data=0xA5..A5.
   - pending=0x08; req0_ready=1 the same cycle.
   - wr_en=1, wr_dst=3, wr_data=0xA5..A5 one cycle later; pending=0x00 the cycle after; err=0.
2. Issue regs 1 and 2; req0 (dst=1) and req1 (dst=2) assert together from reset.
   - Grant order is req0, then req1.
   - wr_en high on 2 consecutive cycles with wr_dst 1 then 2.
3. Both requesters held valid for 6 cycles with dsts pending.
   - Grants alternate 0,1,0,1,0,1; neither is starved.
4. Issue reg 5; chk_addr_1=5 -> hazard=1.
   - During the wr_en cycle for reg 5, hazard is still 1; hazard=0 on the next cycle.
   - chk_dst=5 alone also gives hazard=1 while pending.
5. Issue reg 4 in the same cycle that wr_en=1, wr_dst=4 (a prior issue).
   - pending[4] stays 1; err=0.
   - A write to reg 6 while pending[6]=0 sets err=1, which holds until rst.
6. Assert rst one cycle after a transfer.
   - wr_en=0, pending=0, err=0, readies 0 during rst.
   - After rst, req0 wins the first contention.
